// File: rtl/narnet_seq_ctrl_pkg.sv
// Shared definitions for the NARNet sequencer: state encoding and default
// data-path / framing constants used by the RTL and the bench.
package narnet_seq_ctrl_pkg;

   localparam int unsigned NARNET_N      = 8;
   localparam int unsigned NARNET_Q      = 7;
   localparam int unsigned SEQ_LEN_W     = 9;
   localparam int unsigned SEQ_TIMEOUT   = 64;
   localparam int unsigned SEQ_FLUSH_CYC = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FLUSH = 3'd4,
      ST_ERR   = 3'd5
   } seq_state_e;

endpackage

// File: rtl/narnet_watchdog.sv
// Loadable up-counter with clear/enable; term_c flags the TIMEOUT-th
// enabled cycle since the last clear. Saturates at TIMEOUT.
module narnet_watchdog #(
   parameter  int unsigned TIMEOUT = 64,
   localparam int unsigned W       = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         term_c
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != W'(TIMEOUT))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_c = en_i && (cnt_q >= W'(TIMEOUT - 1));

endmodule

// File: rtl/narnet_seq_ctrl.sv
// Sequencer for one NARNet instance: feeds samples to the net one at a time,
// returns predictions on a valid/ready stream, frames, flushes and watchdogs.
module narnet_seq_ctrl
   import narnet_seq_ctrl_pkg::*;
#(
   parameter int unsigned N         = NARNET_N,
   parameter int unsigned Q         = NARNET_Q,
   parameter int unsigned LEN_W     = SEQ_LEN_W,
   parameter int unsigned TIMEOUT   = SEQ_TIMEOUT,
   parameter int unsigned FLUSH_CYC = SEQ_FLUSH_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             err_clr,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [N-1:0]     s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N-1:0]     m_data,
   output logic             m_last,
   output logic [N-1:0]     nn_x_in,
   output logic             nn_x_ready,
   input  logic [N-1:0]     nn_y_out,
   input  logic             nn_out_ready,
   output logic             nn_rst,
   output logic             busy,
   output logic [LEN_W-1:0] sample_cnt,
   output logic             timeout_err
);

   localparam int unsigned FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   // Data is passed through untouched; Q only documents the format.
   if (Q >= N) begin : g_q_range_check
      $error("narnet_seq_ctrl: Q must be smaller than N");
   end

   seq_state_e       state_q, state_d;
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   logic [N-1:0]     m_data_q, m_data_d;
   logic             m_last_q, m_last_d;
   logic [N-1:0]     nn_x_in_q, nn_x_in_d;
   logic             nn_x_ready_q, nn_x_ready_d;
   logic             nn_rst_q, nn_rst_d;
   logic             busy_q, busy_d;
   logic [LEN_W-1:0] sample_cnt_q, sample_cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             frame_act_q, frame_act_d;
   logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic             accept;
   logic             wd_clr;
   logic             wd_en;
   logic             wd_term;

   assign accept = s_valid && s_ready_q;
   assign wd_clr = (state_q == ST_ISSUE);
   assign wd_en  = (state_q == ST_WAIT);

   narnet_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (wd_clr),
      .en_i       (wd_en),
      .load_i     (1'b0),
      .load_val_i ('0),
      .term_c     (wd_term)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      m_valid_d     = m_valid_q;
      m_data_d      = m_data_q;
      m_last_d      = m_last_q;
      nn_x_in_d     = nn_x_in_q;
      nn_x_ready_d  = 1'b0;
      sample_cnt_d  = sample_cnt_q;
      timeout_err_d = timeout_err_q;
      len_d         = len_q;
      frame_act_d   = frame_act_q;
      flush_cnt_d   = flush_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               nn_x_in_d    = s_data;
               nn_x_ready_d = 1'b1;
               if (!frame_act_q) begin
                  len_d = frame_len;
               end
               frame_act_d  = 1'b1;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (nn_out_ready) begin
               m_data_d     = nn_y_out;
               m_valid_d    = 1'b1;
               sample_cnt_d = sample_cnt_q + LEN_W'(1);
               m_last_d     = (len_q != '0) && ((sample_cnt_q + LEN_W'(1)) == len_q);
               state_d      = ST_HOLD;
            end else if (wd_term) begin
               timeout_err_d = 1'b1;
               state_d       = ST_ERR;
            end
         end
         ST_HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (m_last_q) begin
                  sample_cnt_d = '0;
                  frame_act_d  = 1'b0;
                  flush_cnt_d  = '0;
                  state_d      = ST_FLUSH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
               state_d = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + FL_W'(1);
            end
         end
         ST_ERR: begin
            if (err_clr) begin
               timeout_err_d = 1'b0;
               sample_cnt_d  = '0;
               m_valid_d     = 1'b0;
               frame_act_d   = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs follow the state being entered so they line up with it.
      s_ready_d = (state_d == ST_IDLE) && enable && !timeout_err_d && !m_valid_d;
      nn_rst_d  = (state_d == ST_FLUSH) || (state_d == ST_ERR);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         s_ready_q     <= 1'b0;
         m_valid_q     <= 1'b0;
         m_data_q      <= '0;
         m_last_q      <= 1'b0;
         nn_x_in_q     <= '0;
         nn_x_ready_q  <= 1'b0;
         nn_rst_q      <= 1'b0;
         busy_q        <= 1'b0;
         sample_cnt_q  <= '0;
         timeout_err_q <= 1'b0;
         len_q         <= '0;
         frame_act_q   <= 1'b0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         s_ready_q     <= s_ready_d;
         m_valid_q     <= m_valid_d;
         m_data_q      <= m_data_d;
         m_last_q      <= m_last_d;
         nn_x_in_q     <= nn_x_in_d;
         nn_x_ready_q  <= nn_x_ready_d;
         nn_rst_q      <= nn_rst_d;
         busy_q        <= busy_d;
         sample_cnt_q  <= sample_cnt_d;
         timeout_err_q <= timeout_err_d;
         len_q         <= len_d;
         frame_act_q   <= frame_act_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_last      = m_last_q;
   assign nn_x_in     = nn_x_in_q;
   assign nn_x_ready  = nn_x_ready_q;
   assign nn_rst      = nn_rst_q;
   assign busy        = busy_q;
   assign sample_cnt  = sample_cnt_q;
   assign timeout_err = timeout_err_q;

endmodule
